// File: rtl/cyp2sdram_pkg.sv
// Shared types and default widths for the CDC-FIFO to SDRAM burst writer.
package cyp2sdram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 22;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } wr_state_e;

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry fall-through buffer: an arriving word bypasses to the output when the buffer is empty.
module wr_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    always_comb begin
        in_ready_o  = (cnt_q != 2'd2);
        out_valid_o = (cnt_q != 2'd0) || in_valid_i;
        out_data_o  = '0;
        if (cnt_q != 2'd0) begin
            out_data_o = rd_ptr_q ? mem1_q : mem0_q;
        end else if (in_valid_i) begin
            out_data_o = in_data_i;
        end
        pop  = out_ready_i && (cnt_q != 2'd0);
        // Store only when the word is not consumed straight through.
        push = in_valid_i && in_ready_o && !((cnt_q == 2'd0) && out_ready_i);
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        if (push) begin
            if (wr_ptr_q) begin
                mem1_d = in_data_i;
            end else begin
                mem0_d = in_data_i;
            end
        end
        occ_o = cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_wr_sdram.sv
// Burst-write engine: drains the CDC FIFO into the SDRAM write port in bounded, region-clamped
// bursts, flushing partial bursts after an idle timeout.
module fifo_burst_wr_sdram
    import cyp2sdram_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned LVL_W        = 10,
    parameter int unsigned BURST_LEN    = 256,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned REGION_WORDS = 1 << DEF_ADDR_W,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic              sdram_clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              enable,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_rempty,
    input  logic [LVL_W-1:0]  fifo_rlevel,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_first,
    output logic              wr_last,
    output logic              busy,
    output logic              region_full,
    output logic              wrap_pulse,
    output logic [31:0]       words_total
);

    // Offset/length width must hold REGION_WORDS itself as well as any FIFO level.
    localparam int unsigned OFF_W = ((ADDR_W > LVL_W) ? ADDR_W : LVL_W) + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 2);
    localparam int unsigned PL_W  = DATA_W + ADDR_W + 2;

    wr_state_e         state_q, state_d;
    logic              busy_q, busy_d;
    logic              region_full_q, region_full_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [31:0]       words_total_q, words_total_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [OFF_W-1:0]  fetch_left_q, fetch_left_d;
    logic [OFF_W-1:0]  tag_left_q, tag_left_d;
    logic [ADDR_W-1:0] tag_off_q, tag_off_d;
    logic              tag_first_q, tag_first_d;
    logic              rd_valid_q;

    logic [OFF_W-1:0]  rlevel, room, burst_n;
    logic              to_hit, start, accept, last_acc, buf_in_ready;
    logic [2:0]        occ_after;
    logic [1:0]        buf_occ;
    logic [PL_W-1:0]   pl_in, pl_out;

    assign pl_in = {fifo_rdata, ADDR_W'(BASE_ADDR) + tag_off_q, tag_first_q,
                    (tag_left_q == OFF_W'(1))};

    wr_skid_buf #(
        .W (PL_W)
    ) u_skid (
        .clk_i       (sdram_clk),
        .rst_ni      (rst_n),
        .in_valid_i  (rd_valid_q),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (pl_in),
        .out_valid_o (wr_valid),
        .out_ready_i (wr_ready),
        .out_data_o  (pl_out),
        .occ_o       (buf_occ)
    );

    assign {wr_data, wr_addr, wr_first, wr_last} = pl_out;
    assign busy        = busy_q;
    assign region_full = region_full_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign words_total = words_total_q;

    always_comb begin
        rlevel  = OFF_W'(fifo_rlevel);
        room    = OFF_W'(REGION_WORDS) - offset_q;
        burst_n = rlevel;
        if (OFF_W'(BURST_LEN) < burst_n) burst_n = OFF_W'(BURST_LEN);
        if (room < burst_n) burst_n = room;
        to_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT));
        start  = sdram_init_done && enable && !region_full_q &&
                 ((rlevel >= OFF_W'(BURST_LEN)) || ((rlevel != '0) && to_hit));

        accept   = wr_valid && wr_ready;
        last_acc = accept && wr_last;
        // Words that will sit in the buffer after this cycle; a new read needs a free slot.
        occ_after = 3'(buf_occ) + 3'(rd_valid_q) - 3'(accept);
        fifo_ren  = (state_q == StBurst) && (fetch_left_q != '0) && !fifo_rempty &&
                    (occ_after < 3'd2) && buf_in_ready;
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        region_full_d = region_full_q;
        wrap_pulse_d  = 1'b0;
        words_total_d = words_total_q;
        offset_d      = offset_q;
        fetch_left_d  = fetch_left_q;
        tag_left_d    = tag_left_q;
        tag_off_d     = tag_off_q;
        tag_first_d   = tag_first_q;
        to_cnt_d      = to_cnt_q;

        if (state_q != StIdle || fifo_rempty) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (fifo_ren) fetch_left_d = fetch_left_q - OFF_W'(1);
        if (rd_valid_q) begin
            tag_off_d   = tag_off_q + ADDR_W'(1);
            tag_left_d  = tag_left_q - OFF_W'(1);
            tag_first_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StBurst;
                    busy_d       = 1'b1;
                    fetch_left_d = burst_n;
                    tag_left_d   = burst_n;
                    tag_off_d    = offset_q[ADDR_W-1:0];
                    tag_first_d  = 1'b1;
                end
            end
            StBurst: begin
                // The last word can already be taken in the cycle fetching ends.
                if (fetch_left_q == '0) begin
                    state_d = last_acc ? StIdle : StDrain;
                    busy_d  = !last_acc;
                end
            end
            StDrain: begin
                if (last_acc) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            words_total_d = words_total_q + 32'd1;
            offset_d      = offset_q + OFF_W'(1);
            if (offset_q + OFF_W'(1) == OFF_W'(REGION_WORDS)) begin
                if (WRAP != 0) begin
                    offset_d     = '0;
                    wrap_pulse_d = 1'b1;
                end else begin
                    region_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            region_full_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            words_total_q <= '0;
            offset_q      <= '0;
            to_cnt_q      <= '0;
            fetch_left_q  <= '0;
            tag_left_q    <= '0;
            tag_off_q     <= '0;
            tag_first_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            region_full_q <= region_full_d;
            wrap_pulse_q  <= wrap_pulse_d;
            words_total_q <= words_total_d;
            offset_q      <= offset_d;
            to_cnt_q      <= to_cnt_d;
            fetch_left_q  <= fetch_left_d;
            tag_left_q    <= tag_left_d;
            tag_off_q     <= tag_off_d;
            tag_first_q   <= tag_first_d;
            rd_valid_q    <= fifo_ren;
        end
    end

endmodule

// File: tb/tb_fifo_burst_wr_sdram.sv
// Scoreboard bench for fifo_burst_wr_sdram: a wrapping instance fed from a queue-model FIFO and a
// stop-at-full instance fed from an endless counting source.
module tb_fifo_burst_wr_sdram;

    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 12;
    localparam int unsigned LW       = 10;
    localparam int unsigned BASE     = 100;
    localparam int unsigned REGION   = 40;
    localparam int unsigned F_BASE   = 50;
    localparam int unsigned F_REGION = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rempty = 1'b1;
    logic [LW-1:0] fifo_rlevel = '0;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid, wr_first, wr_last, busy, region_full, wrap_pulse;
    logic          wr_ready = 1'b0;
    logic [31:0]   words_total;

    logic          f_ren, f_wr_valid, f_wr_first, f_wr_last, f_busy, f_region_full, f_wrap;
    logic [DW-1:0] f_rdata = '0;
    logic [DW-1:0] f_wr_data;
    logic [AW-1:0] f_wr_addr;
    logic [31:0]   f_words_total;
    logic          f_src_en = 1'b0;
    logic          chk2_en = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int wrap_cnt = 0;
    int first_cyc = 0;
    int acc2 = 0;
    int src2 = 0;

    logic [DW-1:0]          fq[$];
    logic [DW+AW+1:0]       expq[$];
    logic [DW+AW+1:0]       held, e;
    bit                     stalled = 1'b0;
    logic [DW-1:0]          ld_data = 16'h1000;
    logic [DW-1:0]          exp_data = 16'h1000;
    int                     exp_off = 0;
    logic                   rdy_mode = 1'b0;
    logic [7:0]             rdy_pat = 8'b1011_0110;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_burst_wr_sdram #(
        .DATA_W(DW), .ADDR_W(AW), .LVL_W(LW), .BURST_LEN(16), .BASE_ADDR(BASE),
        .REGION_WORDS(REGION), .WRAP(1), .TIMEOUT(16)
    ) u_dut (
        .sdram_clk(clk), .rst_n(rst_n), .sdram_init_done(init_done), .enable(enable),
        .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
        .fifo_rlevel(fifo_rlevel), .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_first(wr_first), .wr_last(wr_last), .busy(busy),
        .region_full(region_full), .wrap_pulse(wrap_pulse), .words_total(words_total)
    );

    fifo_burst_wr_sdram #(
        .DATA_W(DW), .ADDR_W(AW), .LVL_W(LW), .BURST_LEN(16), .BASE_ADDR(F_BASE),
        .REGION_WORDS(F_REGION), .WRAP(0), .TIMEOUT(0)
    ) u_full (
        .sdram_clk(clk), .rst_n(rst_n), .sdram_init_done(init_done), .enable(enable),
        .fifo_ren(f_ren), .fifo_rdata(f_rdata), .fifo_rempty(!f_src_en),
        .fifo_rlevel(f_src_en ? LW'(500) : LW'(0)), .wr_data(f_wr_data), .wr_addr(f_wr_addr),
        .wr_valid(f_wr_valid), .wr_ready(1'b1), .wr_first(f_wr_first), .wr_last(f_wr_last),
        .busy(f_busy), .region_full(f_region_full), .wrap_pulse(f_wrap),
        .words_total(f_words_total)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(ld_data);
            ld_data++;
        end
    endtask

    task automatic exp_burst(input int n);
        for (int i = 0; i < n; i++) begin
            expq.push_back({exp_data, AW'(BASE + exp_off), (i == 0), (i == n - 1)});
            exp_data++;
            exp_off = (exp_off + 1) % REGION;
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((expq.size() != 0 || busy) && k < 400) begin
            tick(1);
            k++;
        end
        check({name, "_done"}, 64'(k < 400), 64'(1));
        tick(2);
    endtask

    // Queue-model FIFO with registered read data.
    always @(posedge clk) begin
        if (fifo_ren) begin
            n_tests++;
            if (fq.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_underflow: read strobe with 0 words, required >= 1");
            end else begin
                fifo_rdata <= fq.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        fifo_rlevel = LW'(fq.size());
        fifo_rempty = (fq.size() == 0);
    end

    always @(posedge clk) begin
        #2;
        wr_ready = rdy_mode ? rdy_pat[cyc[2:0]] : 1'b1;
    end

    always @(posedge clk) begin
        if (f_ren) begin
            f_rdata <= DW'(src2);
            src2    <= src2 + 1;
        end
    end

    // Scoreboard monitor for the wrapping instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_hold", 64'({wr_valid, wr_data, wr_addr, wr_first, wr_last}),
                      64'({1'b1, held}));
            end
            if (wr_valid && wr_first && !stalled) first_cyc = cyc;
            if (wr_valid && wr_ready) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, required none",
                             wr_addr, wr_data);
                end else begin
                    e = expq.pop_front();
                    check("word", 64'({wr_data, wr_addr, wr_first, wr_last}), 64'(e));
                    acc_cnt++;
                end
            end
            stalled = wr_valid && !wr_ready;
            held    = {wr_data, wr_addr, wr_first, wr_last};
            if (wrap_pulse) wrap_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk2_en && f_wr_valid) begin
            check("full_addr", 64'(f_wr_addr), 64'(AW'(F_BASE + acc2)));
            check("full_data", 64'(f_wr_data), 64'(DW'(acc2)));
            acc2++;
        end
    end

    initial begin
        int k;
        int t_load;
        int a0;
        #12;
        check("rst_wr_valid", 64'(wr_valid), 64'(0));
        check("rst_fifo_ren", 64'(fifo_ren), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_payload", 64'({wr_data, wr_addr, wr_first, wr_last}), 64'(0));
        check("rst_words_total", 64'(words_total), 64'(0));
        check("rst_flags", 64'({region_full, wrap_pulse, f_region_full}), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        init_done = 1'b1;
        enable = 1'b1;

        // Stop-at-full instance: bursts of 16 then 4, then nothing more.
        f_src_en = 1'b1;
        chk2_en = 1'b1;
        k = 0;
        while (!f_region_full && k < 300) begin
            tick(1);
            k++;
        end
        check("full_reached", 64'(k < 300), 64'(1));
        tick(30);
        check("full_accepted", 64'(acc2), 64'(F_REGION));
        check("full_reads", 64'(src2), 64'(F_REGION));
        check("full_words_total", 64'(f_words_total), 64'(F_REGION));
        check("full_idle", 64'({f_busy, f_region_full}), 64'(2'b01));

        // One full burst.
        exp_burst(16);
        load(16);
        tick(3);
        check("busy_in_burst", 64'(busy), 64'(1));
        wait_done("burst16");
        check("words_total_16", 64'(words_total), 64'(16));

        // Partial burst flushed by timeout.
        exp_burst(5);
        load(5);
        t_load = cyc;
        tick(10);
        check("no_early_start", 64'(busy), 64'(0));
        wait_done("timeout5");
        check("timeout_latency", 64'((first_cyc - t_load) inside {[17:19]}), 64'(1));
        check("words_total_21", 64'(words_total), 64'(21));

        // Backpressure.
        rdy_mode = 1'b1;
        exp_burst(16);
        load(16);
        wait_done("stall16");
        rdy_mode = 1'b0;
        check("words_total_37", 64'(words_total), 64'(37));

        // Region end clamps the burst to 3, then wraps to BASE for the remaining 13.
        exp_burst(3);
        exp_burst(13);
        load(16);
        wait_done("wrap");
        check("wrap_pulses", 64'(wrap_cnt), 64'(1));
        check("words_total_53", 64'(words_total), 64'(53));

        // No start while disabled.
        enable = 1'b0;
        a0 = acc_cnt;
        load(16);
        tick(30);
        check("disabled_busy", 64'(busy), 64'(0));
        check("disabled_words", 64'(acc_cnt), 64'(a0));
        exp_burst(16);
        enable = 1'b1;
        wait_done("enable16");
        check("words_total_69", 64'(words_total), 64'(69));

        // Reset in the middle of an 11-word burst.
        exp_burst(11);
        exp_burst(5);
        load(16);
        a0 = acc_cnt;
        k = 0;
        while (acc_cnt < a0 + 4 && k < 200) begin
            tick(1);
            k++;
        end
        check("midburst_reached", 64'(k < 200), 64'(1));
        f_src_en = 1'b0;
        chk2_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_ren_busy", 64'({wr_valid, fifo_ren, busy}), 64'(0));
        check("mid_rst_payload", 64'({wr_data, wr_addr, wr_first, wr_last}), 64'(0));
        check("mid_rst_words_total", 64'(words_total), 64'(0));
        fq.delete();
        expq.delete();
        exp_off = 0;
        exp_data = ld_data;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        exp_burst(16);
        load(16);
        wait_done("after_reset");
        check("words_total_after_reset", 64'(words_total), 64'(16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
